regfile_scoreboard: RTL and testbench

- Parametrised successor to the 32x64 register bank: 2 async read ports, 1 sync write port.
- Generalised data width and depth, hardwired-zero option, write-to-read bypass, and asynchronous clear of all contents.
- Adds a per-register busy scoreboard with reserve/release handshake, flush, and a live busy count, so the datapath can stall on RAW hazards against in-flight writes.

---
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 tb/tb_regfile_scoreboard.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register bank: 2 async read ports, 1 sync write port, plus a per-register busy scoreboard.
// Latency: reads and rsv_ok are combinational; writes, reservations, flush and busy_count settle at the clock edge.
// Backpressure: a reserve of a busy register (or during flush) is refused with rsv_ok=0 and the requester retries.
module regfile_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  eff_busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              wr_live;
  logic              rsv_zero;
  logic              rsv_set;
  logic              rel_hit;

  // Qualify strobes: writes/reserves to the hardwired zero register do nothing, and
  // nothing is forwarded or accepted while reset is held.
  always_comb begin
    wr_live  = rst_n & wr_en & ~((ZERO_REG != 0) && (wr_addr == '0));
    rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
    rel_hit  = wr_live & busy[wr_addr];
  end

  // Busy view after this cycle's write release; a reserve is judged against it.
  always_comb begin
    eff_busy = busy;
    if (wr_live) eff_busy[wr_addr] = 1'b0;
    rsv_ok  = rst_n & rsv_en & ~flush & ~eff_busy[rsv_addr];
    rsv_set = rsv_ok & ~rsv_zero;
  end

  // Next busy vector and matching popcount; flush overrides everything.
  always_comb begin
    busy_nxt  = eff_busy;
    if (rsv_set) busy_nxt[rsv_addr] = 1'b1;
    count_nxt = busy_count + CNT_W'(rsv_set) - CNT_W'(rel_hit);
    if (flush) begin
      busy_nxt  = '0;
      count_nxt = '0;
    end
  end

  // Read port 1: zero register first, then same-cycle write forwarding, then stored state.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_busy1 = busy[rd_addr1];
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
    end else if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
      rd_busy1 = rsv_set && (rsv_addr == rd_addr1);
    end
  end

  // Read port 2: identical priority to port 1.
  always_comb begin
    rd_data2 = regs[rd_addr2];
    rd_busy2 = busy[rd_addr2];
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
      rd_data2 = '0;
      rd_busy2 = 1'b0;
    end else if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
      rd_busy2 = rsv_set && (rsv_addr == rd_addr2);
    end
  end

  // Register storage: async clear of every entry, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard state: busy bits and their registered popcount.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
  logic        wr_en, rsv_en, flush;
  logic [63:0] wr_data;

  logic [63:0] b_rd_data1, b_rd_data2, n_rd_data1, n_rd_data2;
  logic        b_rd_busy1, b_rd_busy2, n_rd_busy1, n_rd_busy2;
  logic        b_rsv_ok, n_rsv_ok;
  logic [5:0]  b_busy_count, n_busy_count;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
    .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(b_rsv_ok),
    .flush(flush), .busy_count(b_busy_count)
  );

  regfile_scoreboard #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_rd_data1), .rd_data2(n_rd_data2),
    .rd_busy1(n_rd_busy1), .rd_busy2(n_rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(n_rsv_ok),
    .flush(flush), .busy_count(n_busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    @(negedge clk);
    wr_en = 0; rsv_en = 0; flush = 0;
    wr_addr = 0; rsv_addr = 0; wr_data = 0;
  endtask

  task automatic test_reset();
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #1;
      checks++; if (b_rd_data1 !== 64'd0) begin errors++; $display("FAIL reset_rd_data1 a=%0d got %h exp 0", a, b_rd_data1); end
      checks++; if (b_rd_busy1 !== 1'b0) begin errors++; $display("FAIL reset_rd_busy1 a=%0d got %b exp 0", a, b_rd_busy1); end
      checks++; if (n_rd_data2 !== 64'd0) begin errors++; $display("FAIL reset_rd_data2 a=%0d got %h exp 0", a, n_rd_data2); end
    end
    checks++; if (b_busy_count !== 6'd0) begin errors++; $display("FAIL reset_busy_count got %0d exp 0", b_busy_count); end
    @(negedge clk); rst_n = 1;
    // write of 0xDEAD to r3 interrupted by reset
    @(negedge clk);
    wr_en = 1; wr_addr = 3; wr_data = 64'hDEAD; rd_addr1 = 3;
    #3 rst_n = 0;
    #1;
    checks++; if (b_rd_data1 !== 64'd0) begin errors++; $display("FAIL reset_no_bypass got %h exp 0", b_rd_data1); end
    @(posedge clk); #1;
    @(negedge clk); wr_en = 0; rst_n = 1;
    #1;
    checks++; if (b_rd_data1 !== 64'd0) begin errors++; $display("FAIL reset_midwrite_r3 got %h exp 0", b_rd_data1); end
    checks++; if (n_rd_data1 !== 64'd0) begin errors++; $display("FAIL reset_midwrite_r3_nb got %h exp 0", n_rd_data1); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1; wr_addr = 5; wr_data = 64'h0123_4567_89AB_CDEF; rd_addr1 = 5; rd_addr2 = 5;
    #1;
    checks++; if (b_rd_data1 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL bypass_same_cycle got %h exp 0123456789abcdef", b_rd_data1); end
    checks++; if (b_rd_data2 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL bypass_port2 got %h exp 0123456789abcdef", b_rd_data2); end
    checks++; if (n_rd_data1 !== 64'd0) begin errors++; $display("FAIL nobypass_old_value got %h exp 0", n_rd_data1); end
    @(negedge clk); wr_en = 0;
    #1;
    checks++; if (n_rd_data1 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL nobypass_next_cycle got %h exp 0123456789abcdef", n_rd_data1); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    wr_en = 1; wr_addr = 0; wr_data = 64'hFFFF; rd_addr1 = 0;
    rsv_en = 1; rsv_addr = 0;
    #1;
    checks++; if (b_rd_data1 !== 64'd0) begin errors++; $display("FAIL zero_bypass_data got %h exp 0", b_rd_data1); end
    checks++; if (b_rsv_ok !== 1'b1) begin errors++; $display("FAIL zero_rsv_ok got %b exp 1", b_rsv_ok); end
    idle();
    #1;
    checks++; if (b_rd_data1 !== 64'd0) begin errors++; $display("FAIL zero_data got %h exp 0", b_rd_data1); end
    checks++; if (b_rd_busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", b_rd_busy1); end
    checks++; if (b_busy_count !== 6'd0) begin errors++; $display("FAIL zero_count got %0d exp 0", b_busy_count); end
  endtask

  task automatic test_reserve();
    @(negedge clk);
    rsv_en = 1; rsv_addr = 7; rd_addr1 = 7;
    #1;
    checks++; if (b_rsv_ok !== 1'b1) begin errors++; $display("FAIL rsv7_ok got %b exp 1", b_rsv_ok); end
    idle(); #1;
    checks++; if (b_busy_count !== 6'd1) begin errors++; $display("FAIL rsv7_count got %0d exp 1", b_busy_count); end
    checks++; if (b_rd_busy1 !== 1'b1) begin errors++; $display("FAIL rsv7_busy got %b exp 1", b_rd_busy1); end
    @(negedge clk); rsv_en = 1; rsv_addr = 7;
    #1;
    checks++; if (b_rsv_ok !== 1'b0) begin errors++; $display("FAIL rsv7_again_ok got %b exp 0", b_rsv_ok); end
    idle(); #1;
    checks++; if (b_busy_count !== 6'd1) begin errors++; $display("FAIL rsv7_again_count got %0d exp 1", b_busy_count); end
    @(negedge clk); wr_en = 1; wr_addr = 7; wr_data = 64'h77;
    #1;
    checks++; if (b_rd_busy1 !== 1'b0) begin errors++; $display("FAIL wr7_bypass_busy got %b exp 0", b_rd_busy1); end
    checks++; if (n_rd_busy1 !== 1'b1) begin errors++; $display("FAIL wr7_nobypass_busy got %b exp 1", n_rd_busy1); end
    idle(); #1;
    checks++; if (b_busy_count !== 6'd0) begin errors++; $display("FAIL wr7_count got %0d exp 0", b_busy_count); end
    checks++; if (b_rd_busy1 !== 1'b0) begin errors++; $display("FAIL wr7_busy got %b exp 0", b_rd_busy1); end
    checks++; if (b_rd_data1 !== 64'h77) begin errors++; $display("FAIL wr7_data got %h exp 77", b_rd_data1); end
  endtask

  task automatic test_write_reserve_same();
    @(negedge clk); rsv_en = 1; rsv_addr = 9; rd_addr1 = 9;
    idle(); #1;
    checks++; if (b_busy_count !== 6'd1) begin errors++; $display("FAIL r9_pre_count got %0d exp 1", b_busy_count); end
    @(negedge clk);
    wr_en = 1; wr_addr = 9; wr_data = 64'h99; rsv_en = 1; rsv_addr = 9;
    #1;
    checks++; if (b_rsv_ok !== 1'b1) begin errors++; $display("FAIL r9_rsv_ok got %b exp 1", b_rsv_ok); end
    checks++; if (b_rd_busy1 !== 1'b1) begin errors++; $display("FAIL r9_bypass_busy got %b exp 1", b_rd_busy1); end
    checks++; if (b_rd_data1 !== 64'h99) begin errors++; $display("FAIL r9_bypass_data got %h exp 99", b_rd_data1); end
    idle(); #1;
    checks++; if (b_busy_count !== 6'd1) begin errors++; $display("FAIL r9_count got %0d exp 1", b_busy_count); end
    checks++; if (b_rd_busy1 !== 1'b1) begin errors++; $display("FAIL r9_busy got %b exp 1", b_rd_busy1); end
    checks++; if (n_rd_data1 !== 64'h99) begin errors++; $display("FAIL r9_data got %h exp 99", n_rd_data1); end
    @(negedge clk); wr_en = 1; wr_addr = 9; wr_data = 64'h99;
    idle(); #1;
    checks++; if (b_busy_count !== 6'd0) begin errors++; $display("FAIL r9_release_count got %0d exp 0", b_busy_count); end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      @(negedge clk); rsv_en = 1; rsv_addr = 5'(r);
    end
    idle(); #1;
    checks++; if (b_busy_count !== 6'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", b_busy_count); end
    @(negedge clk);
    flush = 1; rsv_en = 1; rsv_addr = 4;
    wr_en = 1; wr_addr = 10; wr_data = 64'hAA;
    #1;
    checks++; if (b_rsv_ok !== 1'b0) begin errors++; $display("FAIL flush_rsv_ok got %b exp 0", b_rsv_ok); end
    idle(); #1;
    checks++; if (b_busy_count !== 6'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", b_busy_count); end
    checks++; if (n_busy_count !== 6'd0) begin errors++; $display("FAIL flush_count_nb got %0d exp 0", n_busy_count); end
    for (int r = 1; r <= 4; r++) begin
      rd_addr1 = 5'(r);
      #1;
      checks++; if (b_rd_busy1 !== 1'b0) begin errors++; $display("FAIL flush_busy r%0d got %b exp 0", r, b_rd_busy1); end
    end
    rd_addr2 = 10;
    #1;
    checks++; if (b_rd_data2 !== 64'hAA) begin errors++; $display("FAIL flush_write_data got %h exp aa", b_rd_data2); end
  endtask

  task automatic test_back_to_back();
    // reserve r11 then r12 on consecutive edges, then release both with writes
    @(negedge clk); rsv_en = 1; rsv_addr = 11;
    @(negedge clk); rsv_addr = 12; rd_addr1 = 11; rd_addr2 = 12;
    #1;
    checks++; if (b_rsv_ok !== 1'b1) begin errors++; $display("FAIL b2b_rsv12_ok got %b exp 1", b_rsv_ok); end
    idle(); #1;
    checks++; if (b_busy_count !== 6'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", b_busy_count); end
    checks++; if ({b_rd_busy1, b_rd_busy2} !== 2'b11) begin errors++; $display("FAIL b2b_busy got %b exp 11", {b_rd_busy1, b_rd_busy2}); end
    @(negedge clk); wr_en = 1; wr_addr = 11; wr_data = 64'h11;
    @(negedge clk); wr_addr = 12; wr_data = 64'h12;
    idle(); #1;
    checks++; if (b_busy_count !== 6'd0) begin errors++; $display("FAIL b2b_release_count got %0d exp 0", b_busy_count); end
    checks++; if (b_rd_data2 !== 64'h12) begin errors++; $display("FAIL b2b_data12 got %h exp 12", b_rd_data2); end
  endtask

  initial begin
    rst_n = 0; wr_en = 0; rsv_en = 0; flush = 0;
    wr_addr = 0; rsv_addr = 0; wr_data = 0; rd_addr1 = 0; rd_addr2 = 0;
    @(negedge clk);
    test_reset();
    test_bypass();
    test_zero_reg();
    test_reserve();
    test_write_reserve_same();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
